// File: rtl/seq_divider_8_bit_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_divider_8_bit_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_8_bit_if.sv
// Start/busy/done request-result bundle between a divider client (master) and the divider (slave).
interface seq_divider_8_bit_if
  import seq_divider_8_bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_8_bit_sub.sv
// Ripple-borrow subtractor a - b over WIDTH+1 bits, built from full-adder cells (a + ~b + 1).
// Only the low WIDTH difference bits are returned; the top cell's outcome is carried by borrow.
module sub_stage_8_bit
  import seq_divider_8_bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   nb;
  logic [WIDTH+1:0] c;

  assign c[0] = 1'b1;

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_cell
    assign nb[gi]   = ~b[gi];
    assign c[gi+1]  = (a[gi] & nb[gi]) | (c[gi] & (a[gi] ^ nb[gi]));
    if (gi < WIDTH) begin : g_sum
      assign diff[gi] = a[gi] ^ nb[gi] ^ c[gi];
    end
  end

  assign borrow = ~c[WIDTH+1];

endmodule

// File: rtl/seq_divider_8_bit.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// Results are held in dedicated registers so they stay stable until the next division completes.
module seq_divider_8_bit
  import seq_divider_8_bit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider_8_bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Shift the next dividend bit into the partial remainder; the old R MSB stays as bit WIDTH.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  sub_stage_8_bit #(.WIDTH(WIDTH)) u_sub (
    .a      (trial),
    .b      ({1'b0, d_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    r_next     = r_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            q_next     = bus.dividend;
            d_next     = bus.divisor;
            r_next     = '0;
            cnt_next   = CW'(WIDTH);
            state_next = CALC;
          end else begin
            quot_next  = '1;
            rem_next   = bus.dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      CALC: begin
        // Restore on borrow by keeping the trial value instead of the difference.
        q_next   = {q_reg[WIDTH-2:0], ~borrow};
        r_next   = borrow ? trial[WIDTH-1:0] : diff;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          quot_next  = q_next;
          rem_next   = r_next;
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_reg == CALC);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider_8_bit.sv
// Self-checking bench for seq_divider_8_bit: directed cases plus randomized vectors
// compared against plain integer division and the quotient/remainder invariant.
module tb_seq_divider_8_bit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_divider_8_bit_if #(.WIDTH(W)) bus ();

  seq_divider_8_bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Present a request for one cycle; returns #1 after the edge that samples it.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges after the sampling edge, bn = busy samples seen.
  task automatic wait_done(input string tag, output int lat, output int bn);
    lat = 0;
    bn  = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) bn++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".done"}, bus.done, 1);
    check({tag, ".busy_at_done"}, bus.busy, 0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    model(a, b, eq, er, ez);
    check({tag, ".q"}, bus.quotient, eq);
    check({tag, ".r"}, bus.remainder, er);
    check({tag, ".dbz"}, bus.div_by_zero, ez);
    if (b != 0) begin
      check({tag, ".inv"}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
      check({tag, ".r_lt_d"}, 32'(bus.remainder < b), 1);
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bn;
    launch(a, b);
    wait_done(tag, lat, bn);
    check({tag, ".lat"}, lat, (b == 0) ? 0 : W);
    check({tag, ".busy_cycles"}, bn, (b == 0) ? 0 : W);
    check_result(tag, a, b);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, bus.done, 0);
    $display("div %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d",
             tag, a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, seen;
    logic [W-1:0] ra, rb;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.q", bus.quotient, 0);
    check("reset.r", bus.remainder, 0);
    check("reset.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    run_div("d200_7", 8'd200, 8'd7);
    run_div("d255_1", 8'd255, 8'd1);
    run_div("d5_9", 8'd5, 8'd9);
    run_div("d255_255", 8'd255, 8'd255);
    run_div("d77_0", 8'd77, 8'd0);
    run_div("d10_3", 8'd10, 8'd3);

    // Re-request with different operands while busy; must be ignored.
    launch(8'd100, 8'd3);
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ign", lat, bn);
    check_result("busy_ign", 8'd100, 8'd3);
    $display("div busy_ign: 100 / 3 -> q=%0d r=%0d", bus.quotient, bus.remainder);

    // Start asserted only during the DONE cycle must not launch a division.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done_ign.done", bus.done, 0);
    @(posedge clk);
    #1;
    check("done_ign.busy", bus.busy, 0);
    check("done_ign.q", bus.quotient, 33);
    $display("div done_ign: start during DONE -> busy=%0d", bus.busy);

    // Asynchronous reset in the middle of a division.
    launch(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async.busy", bus.busy, 0);
    check("rst_async.done", bus.done, 0);
    check("rst_async.q", bus.quotient, 0);
    check("rst_async.r", bus.remainder, 0);
    check("rst_async.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("rst_async.no_activity", seen, 0);
    $display("div rst_async: reset mid-operation, activity after release=%0d", seen);
    run_div("d9_2", 8'd9, 8'd2);

    // Back-to-back: run_div returns in the first IDLE cycle after done.
    run_div("b2b_60_7", 8'd60, 8'd7);
    run_div("b2b_61_7", 8'd61, 8'd7);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      run_div($sformatf("rnd%0d", i), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
